// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// cfg_chain_loader : frames host commands/words into a serial config chain.
// Rev 1.0
// ============================================================================
module cfg_chain_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  crst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [LEN_WIDTH-1:0]  cmd_nbits,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [WORD_WIDTH-1:0] data_word,
  output logic                  cfg_out_start,
  output logic                  cfg_bit_out,
  output logic                  cfg_bit_out_valid,
  output logic                  done
);

  localparam int IDX_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int HCNT_W = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORD_WIDTH - 1);
  localparam logic [HCNT_W-1:0]  LAST_HDR = HCNT_W'(ID_WIDTH - 1);
  localparam logic [LEN_WIDTH:0] WORD_LEN = (LEN_WIDTH + 1)'(WORD_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ID_WIDTH-1:0]   id_sh;
  logic [HCNT_W-1:0]     hdr_cnt;
  logic [LEN_WIDTH-1:0]  bits_left;
  logic [LEN_WIDTH-1:0]  bits_unbuf;
  logic [WORD_WIDTH-1:0] word_buf;
  logic                  buf_full;
  logic [IDX_W-1:0]      bit_idx;
  logic                  emit;
  logic                  load;
  logic                  word_last_bit;

  assign emit          = (state == S_DATA) && buf_full;
  assign word_last_bit = emit && (bit_idx == LAST_IDX);
  assign load          = data_ready && data_valid;

  always_ff @(posedge clk or posedge crst) begin
    if (crst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_START;
      S_START: state_nxt = S_HDR;
      S_HDR:   if (hdr_cnt == LAST_HDR)
                 state_nxt = (bits_left == '0) ? S_DONE : S_DATA;
      S_DATA:  if (emit && (bits_left == LEN_WIDTH'(1))) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready         = 1'b0;
    cfg_out_start     = 1'b0;
    cfg_bit_out       = 1'b0;
    cfg_bit_out_valid = 1'b0;
    done              = 1'b0;
    data_ready        = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_START: cfg_out_start = 1'b1;
      S_HDR: begin
        cfg_bit_out_valid = 1'b1;
        cfg_bit_out       = id_sh[ID_WIDTH-1];
        data_ready        = (bits_unbuf != '0) && !buf_full;
      end
      S_DATA: begin
        cfg_bit_out_valid = buf_full;
        cfg_bit_out       = buf_full && word_buf[bit_idx];
        // Refill on the last bit of the word so streaming has no bubble.
        data_ready        = (bits_unbuf != '0) && (!buf_full || (bit_idx == LAST_IDX));
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      id_sh      <= '0;
      hdr_cnt    <= '0;
      bits_left  <= '0;
      bits_unbuf <= '0;
      word_buf   <= '0;
      buf_full   <= 1'b0;
      bit_idx    <= '0;
    end else begin
      if ((state == S_IDLE) && cmd_valid) begin
        id_sh      <= cmd_id;
        hdr_cnt    <= '0;
        bits_left  <= cmd_nbits;
        bits_unbuf <= cmd_nbits;
        buf_full   <= 1'b0;
        bit_idx    <= '0;
      end
      if (state == S_HDR) begin
        id_sh   <= id_sh << 1;
        hdr_cnt <= hdr_cnt + HCNT_W'(1);
      end
      if (emit) begin
        bits_left <= bits_left - LEN_WIDTH'(1);
        if (word_last_bit) begin
          bit_idx  <= '0;
          buf_full <= 1'b0;
        end else begin
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
      if (load) begin
        word_buf <= data_word;
        buf_full <= 1'b1;
        bit_idx  <= '0;
        // Only the last word may be partial; its unused upper bits are never emitted.
        if ({1'b0, bits_unbuf} > WORD_LEN) bits_unbuf <= bits_unbuf - WORD_LEN[LEN_WIDTH-1:0];
        else                               bits_unbuf <= '0;
      end
      if (state == S_DONE) buf_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// tb_cfg_chain_loader : directed self-checking bench, 32-bit and 8-bit word instances.
module tb_cfg_chain_loader;

  logic        clk = 1'b0;
  logic        crst;
  logic        sel;
  logic        cmd_valid;
  logic        data_valid;
  logic [2:0]  cmd_id;
  logic [15:0] cmd_nbits;
  logic [31:0] data_word;

  logic a_cmd_ready, a_data_ready, a_start, a_bit, a_valid, a_done;
  logic b_cmd_ready, b_data_ready, b_start, b_bit, b_valid, b_done;

  always #5 clk = ~clk;

  cfg_chain_loader #(.WORD_WIDTH(32), .ID_WIDTH(3), .LEN_WIDTH(16)) dut_a (
    .clk(clk), .crst(crst),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready),
    .cmd_id(cmd_id), .cmd_nbits(cmd_nbits),
    .data_valid(data_valid && !sel), .data_ready(a_data_ready), .data_word(data_word),
    .cfg_out_start(a_start), .cfg_bit_out(a_bit), .cfg_bit_out_valid(a_valid), .done(a_done)
  );

  cfg_chain_loader #(.WORD_WIDTH(8), .ID_WIDTH(3), .LEN_WIDTH(16)) dut_b (
    .clk(clk), .crst(crst),
    .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready),
    .cmd_id(cmd_id), .cmd_nbits(cmd_nbits),
    .data_valid(data_valid && sel), .data_ready(b_data_ready), .data_word(data_word[7:0]),
    .cfg_out_start(b_start), .cfg_bit_out(b_bit), .cfg_bit_out_valid(b_valid), .done(b_done)
  );

  wire m_cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
  wire m_data_ready = sel ? b_data_ready : a_data_ready;
  wire m_start      = sel ? b_start      : a_start;
  wire m_bit        = sel ? b_bit        : a_bit;
  wire m_valid      = sel ? b_valid      : a_valid;
  wire m_done       = sel ? b_done       : a_done;

  int tests_run = 0;
  int fails     = 0;

  // Per-frame observations gathered by run_frame.
  int          start_k, start_cnt, done_k, done_cnt, ready_k, hs;
  int          overlap, junk, busy_rdy, hdr_n, first_hdr_k;
  logic [2:0]  hdr_bits;
  bit          timeout, aborted;
  bit          dq[$];
  int          dk[$];
  logic [31:0] feed[$];

  // Drives one command and records outputs per cycle; k counts cycles after the accept edge.
  task automatic run_frame(input bit use8, input logic [2:0] id, input logic [15:0] nb,
                           input int stall_at, input int stall_len, input int rst_at);
    int stall_left;
    bit pop_pending;
    start_k = -1; start_cnt = 0; done_k = -1; done_cnt = 0; ready_k = -1; hs = 0;
    overlap = 0; junk = 0; busy_rdy = 0; hdr_n = 0; hdr_bits = '0; first_hdr_k = -1;
    dq.delete(); dk.delete(); timeout = 0; aborted = 0;
    stall_left = 0; pop_pending = 0;
    @(negedge clk);
    sel = use8; cmd_id = id; cmd_nbits = nb; cmd_valid = 1'b1;
    data_valid = (feed.size() > 0);
    data_word  = (feed.size() > 0) ? feed[0] : '0;
    if (data_valid && m_data_ready) begin hs++; pop_pending = 1; end
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (pop_pending) begin void'(feed.pop_front()); pop_pending = 0; end
      if ((int'(m_start) + int'(m_valid) + int'(m_done)) > 1) overlap++;
      if (!m_valid && m_bit) junk++;
      if (m_start) begin start_cnt++; if (start_k < 0) start_k = k; end
      if (m_valid) begin
        if (hdr_n < 3) begin
          hdr_bits = {hdr_bits[1:0], m_bit};
          if (hdr_n == 0) first_hdr_k = k;
          hdr_n++;
        end else begin
          dq.push_back(m_bit);
          dk.push_back(k);
          if (dq.size() == stall_at + 1) stall_left = stall_len;
          if (rst_at >= 0 && dq.size() == rst_at + 1) begin
            #2 crst = 1'b1;
            aborted = 1; data_valid = 1'b0;
            return;
          end
        end
      end
      if (m_done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (m_cmd_ready && done_k < 0) busy_rdy++;
      if (m_cmd_ready && done_k >= 0) begin ready_k = k; data_valid = 1'b0; return; end
      data_valid = (feed.size() > 0) && (stall_left == 0);
      if (stall_left > 0) stall_left--;
      data_word = (feed.size() > 0) ? feed[0] : '0;
      if (data_valid && m_data_ready) begin hs++; pop_pending = 1; end
    end
    timeout = 1; cmd_valid = 1'b0; data_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    sel = 0; cmd_valid = 0; data_valid = 0; cmd_id = '0; cmd_nbits = '0; data_word = '0;
    crst = 1'b1;
    #1;
    got = {a_start, a_valid, a_bit, a_done, a_data_ready, a_cmd_ready};
    tests_run++;
    if (got !== 6'b000001) begin fails++; $display("FAIL reset_async got=%b exp=000001", got); end
    repeat (3) @(negedge clk);
    crst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      got = {a_start, a_valid, a_bit, a_done, a_data_ready, a_cmd_ready};
      tests_run++;
      if (got !== 6'b000001) begin fails++; $display("FAIL reset_idle cyc=%0d got=%b exp=000001", c, got); end
      if (c == 9) begin data_valid = 1'b1; data_word = 32'hFFFF_FFFF; end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [63:0] got;
    feed = '{32'h0000_00A5, 32'hFFFF_FFFF};
    run_frame(0, 3'd5, 16'd8, -1, 0, -1);
    got = '0;
    foreach (dq[i]) got[i] = dq[i];
    tests_run++; if (timeout !== 1'b0) begin fails++; $display("FAIL basic_timeout got=%0b exp=0", timeout); end
    tests_run++; if (start_k != 1 || start_cnt != 1) begin fails++; $display("FAIL basic_start k=%0d n=%0d exp k=1 n=1", start_k, start_cnt); end
    tests_run++; if (hdr_bits !== 3'b101 || first_hdr_k != 2) begin fails++; $display("FAIL basic_hdr got=%b k=%0d exp=101 k=2", hdr_bits, first_hdr_k); end
    tests_run++; if (dq.size() != 8 || got[7:0] !== 8'hA5) begin fails++; $display("FAIL basic_data n=%0d got=%h exp n=8 a5", dq.size(), got[7:0]); end
    tests_run++; if (dk.size() != 8 || dk[0] != 5 || dk[7] != 12) begin fails++; $display("FAIL basic_data_timing n=%0d exp first=5 last=12", dk.size()); end
    tests_run++; if (done_k != 13 || done_cnt != 1) begin fails++; $display("FAIL basic_done k=%0d n=%0d exp k=13 n=1", done_k, done_cnt); end
    tests_run++; if (ready_k != 14) begin fails++; $display("FAIL basic_ready k=%0d exp=14", ready_k); end
    tests_run++; if (hs != 1) begin fails++; $display("FAIL basic_handshakes got=%0d exp=1", hs); end
    tests_run++; if (overlap != 0 || junk != 0 || busy_rdy != 0) begin fails++; $display("FAIL basic_clean ovl=%0d junk=%0d rdy=%0d exp 0", overlap, junk, busy_rdy); end
    feed.delete();
  endtask

  task automatic test_two_words();
    logic [63:0] got;
    int last_k;
    feed = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    run_frame(0, 3'd3, 16'd40, -1, 0, -1);
    got = '0;
    foreach (dq[i]) got[i] = dq[i];
    last_k = (dk.size() == 40) ? dk[39] : -1;
    tests_run++; if (timeout !== 1'b0) begin fails++; $display("FAIL two_timeout got=%0b exp=0", timeout); end
    tests_run++; if (hdr_bits !== 3'b011) begin fails++; $display("FAIL two_hdr got=%b exp=011", hdr_bits); end
    tests_run++; if (dq.size() != 40 || got[39:0] !== 40'hEF_1234_5678) begin fails++; $display("FAIL two_data n=%0d got=%h exp n=40 ef12345678", dq.size(), got[39:0]); end
    tests_run++; if (dk.size() < 1 || dk[0] != 5 || last_k != 44) begin fails++; $display("FAIL two_stream last=%0d exp first=5 last=44", last_k); end
    tests_run++; if (hs != 2) begin fails++; $display("FAIL two_handshakes got=%0d exp=2", hs); end
    tests_run++; if (done_k != 45 || ready_k != 46) begin fails++; $display("FAIL two_done done=%0d ready=%0d exp 45 46", done_k, ready_k); end
    tests_run++; if (overlap != 0 || junk != 0) begin fails++; $display("FAIL two_clean ovl=%0d junk=%0d exp 0", overlap, junk); end
    feed.delete();
  endtask

  task automatic test_stall();
    logic [63:0] got;
    int gap, span;
    feed = '{32'h0000_003C, 32'h0000_0096};
    run_frame(1, 3'd6, 16'd16, 7, 3, -1);
    got = '0;
    foreach (dq[i]) got[i] = dq[i];
    gap  = (dk.size() == 16) ? dk[8] - dk[7] : -1;
    span = (dk.size() == 16) ? dk[15] - dk[0] + 1 : -1;
    tests_run++; if (timeout !== 1'b0) begin fails++; $display("FAIL stall_timeout got=%0b exp=0", timeout); end
    tests_run++; if (hdr_bits !== 3'b110) begin fails++; $display("FAIL stall_hdr got=%b exp=110", hdr_bits); end
    tests_run++; if (dq.size() != 16 || got[15:0] !== 16'h963C) begin fails++; $display("FAIL stall_data n=%0d got=%h exp n=16 963c", dq.size(), got[15:0]); end
    tests_run++; if (gap != 4 || span != 19) begin fails++; $display("FAIL stall_gap gap=%0d span=%0d exp 4 19", gap, span); end
    tests_run++; if (hs != 2) begin fails++; $display("FAIL stall_handshakes got=%0d exp=2", hs); end
    tests_run++; if (done_k != 24 || ready_k != 25) begin fails++; $display("FAIL stall_done done=%0d ready=%0d exp 24 25", done_k, ready_k); end
    tests_run++; if (overlap != 0 || junk != 0) begin fails++; $display("FAIL stall_clean ovl=%0d junk=%0d exp 0", overlap, junk); end
    feed.delete();
  endtask

  task automatic test_zero_len();
    feed = '{32'h0000_0055};
    run_frame(0, 3'd2, 16'd0, -1, 0, -1);
    tests_run++; if (timeout !== 1'b0) begin fails++; $display("FAIL zero_timeout got=%0b exp=0", timeout); end
    tests_run++; if (start_k != 1 || hdr_bits !== 3'b010 || first_hdr_k != 2) begin fails++; $display("FAIL zero_hdr start=%0d hdr=%b k=%0d exp 1 010 2", start_k, hdr_bits, first_hdr_k); end
    tests_run++; if (dq.size() != 0) begin fails++; $display("FAIL zero_data n=%0d exp=0", dq.size()); end
    tests_run++; if (done_k != 5 || ready_k != 6) begin fails++; $display("FAIL zero_done done=%0d ready=%0d exp 5 6", done_k, ready_k); end
    tests_run++; if (hs != 0) begin fails++; $display("FAIL zero_handshakes got=%0d exp=0", hs); end
    feed.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0]  got;
    logic [63:0] d;
    int pulses;
    feed = '{32'hCAFE_F00D, 32'h0BAD_BEEF};
    run_frame(0, 3'd4, 16'd64, -1, 0, 20);
    #1;
    got = {a_start, a_valid, a_bit, a_done, a_data_ready, a_cmd_ready};
    tests_run++; if (aborted !== 1'b1) begin fails++; $display("FAIL rstmid_reach aborted=%0b exp=1", aborted); end
    tests_run++; if (got !== 6'b000001) begin fails++; $display("FAIL rstmid_async got=%b exp=000001", got); end
    feed.delete();
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    crst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_start || a_valid || a_done || a_data_ready) pulses++;
    end
    tests_run++; if (pulses != 0) begin fails++; $display("FAIL rstmid_quiet pulses=%0d exp=0", pulses); end
    feed = '{32'h0000_0009};
    run_frame(0, 3'd1, 16'd4, -1, 0, -1);
    d = '0;
    foreach (dq[i]) d[i] = dq[i];
    tests_run++; if (timeout !== 1'b0) begin fails++; $display("FAIL rstmid_next_timeout got=%0b exp=0", timeout); end
    tests_run++; if (start_k != 1 || hdr_bits !== 3'b001) begin fails++; $display("FAIL rstmid_next_hdr start=%0d hdr=%b exp 1 001", start_k, hdr_bits); end
    tests_run++; if (dq.size() != 4 || d[3:0] !== 4'h9 || dk[0] != 5) begin fails++; $display("FAIL rstmid_next_data n=%0d got=%h exp n=4 9", dq.size(), d[3:0]); end
    tests_run++; if (done_k != 9 || ready_k != 10 || hs != 1) begin fails++; $display("FAIL rstmid_next_done done=%0d ready=%0d hs=%0d exp 9 10 1", done_k, ready_k, hs); end
    feed.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_words();
    test_stall();
    test_zero_len();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cfg_chain_loader.md
CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 Parameter WORD_WIDTH, default 32: width of each host payload word.
REQ-002 Parameter ID_WIDTH, default 3: width of the target ID header sent after start.
REQ-003 Parameter LEN_WIDTH, default 16: width of the payload bit-count field.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-006 Port crst  input  1: asynchronous, active-high reset.
REQ-007 Port cmd_valid  input  1: a command is offered.
REQ-008 Port cmd_ready  output  1: the loader accepts a command.
REQ-009 Port cmd_id  input  ID_WIDTH: target ID sent in the header.
REQ-010 Port cmd_nbits  input  LEN_WIDTH: number of payload bits to send.
REQ-011 Port data_valid  input  1: a payload word is offered.
REQ-012 Port data_ready  output  1: the loader accepts a payload word.
REQ-013 Port data_word  input  WORD_WIDTH: payload word, sent LSB first.
REQ-014 Port cfg_out_start  output  1: one-cycle frame-start pulse to the first config_block of the chain.
REQ-015 Port cfg_bit_out  output  1: serial config bit.
REQ-016 Port cfg_bit_out_valid  output  1: cfg_bit_out is valid this cycle.
REQ-017 Port done  output  1: one-cycle pulse when a frame completes.

Function
REQ-018 States SHALL be IDLE, START, HDR, DATA and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready the loader SHALL latch cmd_id and cmd_nbits and go to START.
REQ-020 START SHALL last exactly 1 cycle with cfg_out_start=1, cfg_bit_out_valid=0; the next state is HDR.
REQ-021 HDR SHALL last exactly ID_WIDTH cycles, emitting the ID MSB first with cfg_bit_out_valid=1; next state is DATA, or DONE if the latched nbits==0.
REQ-022 One payload word buffer plus a bit index SHALL be used; data_ready=1 in HDR or DATA when more words are still needed and (the buffer is empty, or this cycle emits bit WORD_WIDTH-1 of the buffered word).
REQ-023 In DATA, a cycle with a buffered word SHALL emit its next bit (LSB first) with valid=1 and decrement the remaining-bit count; with an empty buffer it SHALL emit valid=0 and cfg_bit_out=0 (a stall), with no bit lost or duplicated.
REQ-024 When data_valid is held high, payload bits SHALL stream with no idle cycles across word boundaries.
REQ-025 Words needed SHALL equal ceil(nbits/WORD_WIDTH); unused upper bits of the last word SHALL be discarded, and no extra data handshake SHALL occur.
REQ-026 After the last payload bit, the state SHALL be DONE for 1 cycle with done=1, then IDLE.
REQ-027 cfg_out_start, cfg_bit_out_valid and done SHALL never be high in the same cycle.
REQ-028 Outside HDR and DATA-emit cycles, cfg_bit_out SHALL be 0.
REQ-029 cmd_valid outside IDLE SHALL be ignored; data_valid in IDLE, START or DONE SHALL be ignored.

Reset
REQ-030 crst SHALL immediately (asynchronously) force IDLE, clear the word buffer and counters, and drive all outputs to 0 except cmd_ready, which is 1 once in IDLE.
REQ-031 Reset mid-frame SHALL abandon the frame with no further start, bit or done pulses; the next command after reset release SHALL run normally.

Verification
REQ-032 Reset release, no stimulus -> cfg_out_start=cfg_bit_out_valid=done=data_ready=0, cmd_ready=1, held indefinitely.
REQ-033 Command accepted at edge T with id=5, nbits=8, word 0xA5 available -> start at T+1; header 1,0,1 at T+2..T+4; data 1,0,1,0,0,1,0,1 at T+5..T+12; done at T+13; cmd_ready=1 at T+14.
REQ-034 nbits=40, two words offered with data_valid held -> exactly 2 data handshakes; 40 consecutive valid bits (word0[31:0], then word1[7:0]); word1[31:8] never emitted.
REQ-035 nbits=16, data_valid dropped for 3 cycles after bit 7 -> valid=0 for exactly 3 cycles, then bits 8..15 follow in order; the total count of valid bits is 16.
REQ-036 id=2, nbits=0 -> start pulse, header bits 0,1,0, done on the next cycle, no data handshake.
REQ-037 crst asserted during bit 20 of a 64-bit frame -> outputs 0 in the same cycle with no clock edge needed; a following id=1, nbits=4 command completes per REQ-033 timing.
